// File: rtl/grover_pkg.sv
// Shared types and constants for the Grover search emulator sequencer.
package grover_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT    = 3'd1,
    ST_OR_WAIT = 3'd2,
    ST_OR_WB   = 3'd3,
    ST_DF_WAIT = 3'd4,
    ST_DF_WB   = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  // Register-bank input mux encoding; code 3 is never driven.
  localparam logic [1:0] SRC_INIT   = 2'd0;
  localparam logic [1:0] SRC_ORACLE = 2'd1;
  localparam logic [1:0] SRC_DIFF   = 2'd2;

endpackage

// File: rtl/grover_wait_counter.sv
// Loadable down-counter that times the oracle and diffusion pipeline waits.
module grover_wait_counter #(
  parameter int W = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_loadVal,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Load takes priority; otherwise count down while enabled and stick at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadVal;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/grover_sequencer.sv
// Sequences initial load plus N oracle/diffusion iterations into the state-vector bank.
import grover_pkg::*;

module grover_sequencer #(
  parameter int ITER_W     = 8,
  parameter int ORACLE_LAT = 2,
  parameter int DIFF_LAT   = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [ITER_W-1:0] i_iter_target,
  output logic              o_reg_en,
  output logic [1:0]        o_sel_src,
  output logic              o_oracle_en,
  output logic              o_diff_en,
  output logic [ITER_W-1:0] o_iter_cnt,
  output logic              o_busy,
  output logic              o_done
);

  // The wait counter only ever holds LAT-1, so size it for the longer pipeline.
  localparam int MAX_LAT = (ORACLE_LAT > DIFF_LAT) ? ORACLE_LAT : DIFF_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] OR_LOAD = CNT_W'(ORACLE_LAT - 1);
  localparam logic [CNT_W-1:0] DF_LOAD = CNT_W'(DIFF_LAT - 1);

  state_t            r_state;
  state_t            w_nextState;
  logic [ITER_W-1:0] r_target;
  logic [ITER_W-1:0] r_iterCnt;
  logic [ITER_W-1:0] w_iterNext;
  logic              w_cntLoad;
  logic              w_cntEn;
  logic [CNT_W-1:0]  w_cntLoadVal;
  logic              w_cntZero;

  logic              w_regEn;
  logic [1:0]        w_selSrc;
  logic              w_oracleEn;
  logic              w_diffEn;
  logic              w_busy;
  logic              w_done;
  logic              r_regEn;
  logic [1:0]        r_selSrc;
  logic              r_oracleEn;
  logic              r_diffEn;
  logic              r_busy;
  logic              r_done;

  assign w_iterNext = r_iterCnt + 1'b1;

  grover_wait_counter #(
    .W(CNT_W)
  ) u_waitCounter (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_load   (w_cntLoad),
    .i_en     (w_cntEn),
    .i_loadVal(w_cntLoadVal),
    .o_zero   (w_cntZero)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; abort overrides everything outside IDLE.
  always_comb begin
    w_nextState = r_state;
    if ((r_state != ST_IDLE) && i_abort) begin
      w_nextState = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    if (i_start) w_nextState = ST_INIT;
        ST_INIT:    w_nextState = (r_target == '0) ? ST_DONE : ST_OR_WAIT;
        ST_OR_WAIT: if (w_cntZero) w_nextState = ST_OR_WB;
        ST_OR_WB:   w_nextState = ST_DF_WAIT;
        ST_DF_WAIT: if (w_cntZero) w_nextState = ST_DF_WB;
        ST_DF_WB:   w_nextState = (w_iterNext == r_target) ? ST_DONE : ST_OR_WAIT;
        ST_DONE:    w_nextState = ST_IDLE;
        default:    w_nextState = ST_IDLE;
      endcase
    end
  end

  // Reload the shared wait counter on entry to either wait state.
  always_comb begin
    w_cntLoad    = 1'b0;
    w_cntLoadVal = OR_LOAD;
    w_cntEn      = (r_state == ST_OR_WAIT) || (r_state == ST_DF_WAIT);
    if ((w_nextState == ST_OR_WAIT) && (r_state != ST_OR_WAIT)) begin
      w_cntLoad    = 1'b1;
      w_cntLoadVal = OR_LOAD;
    end else if ((w_nextState == ST_DF_WAIT) && (r_state != ST_DF_WAIT)) begin
      w_cntLoad    = 1'b1;
      w_cntLoadVal = DF_LOAD;
    end
  end

  // Latch the target on an accepted start and count iterations on diffusion write-back.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_target  <= '0;
      r_iterCnt <= '0;
    end else if ((r_state == ST_IDLE) && i_start) begin
      r_target  <= i_iter_target;
      r_iterCnt <= '0;
    end else if ((r_state == ST_DF_WB) && !i_abort) begin
      r_iterCnt <= w_iterNext;
    end
  end

  // Output decode from the upcoming state so the registered outputs track the current state.
  always_comb begin
    w_regEn    = 1'b0;
    w_selSrc   = SRC_INIT;
    w_oracleEn = 1'b0;
    w_diffEn   = 1'b0;
    w_busy     = (w_nextState != ST_IDLE);
    w_done     = 1'b0;
    case (w_nextState)
      ST_INIT: begin
        w_regEn  = 1'b1;
        w_selSrc = SRC_INIT;
      end
      ST_OR_WAIT: begin
        w_oracleEn = 1'b1;
        w_selSrc   = SRC_ORACLE;
      end
      ST_OR_WB: begin
        w_oracleEn = 1'b1;
        w_selSrc   = SRC_ORACLE;
        w_regEn    = 1'b1;
      end
      ST_DF_WAIT: begin
        w_diffEn = 1'b1;
        w_selSrc = SRC_DIFF;
      end
      ST_DF_WB: begin
        w_diffEn = 1'b1;
        w_selSrc = SRC_DIFF;
        w_regEn  = 1'b1;
      end
      ST_DONE: w_done = 1'b1;
      default: w_done = 1'b0;
    endcase
  end

  // Output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_regEn    <= 1'b0;
      r_selSrc   <= SRC_INIT;
      r_oracleEn <= 1'b0;
      r_diffEn   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_regEn    <= w_regEn;
      r_selSrc   <= w_selSrc;
      r_oracleEn <= w_oracleEn;
      r_diffEn   <= w_diffEn;
      r_busy     <= w_busy;
      r_done     <= w_done;
    end
  end

  assign o_reg_en    = r_regEn;
  assign o_sel_src   = r_selSrc;
  assign o_oracle_en = r_oracleEn;
  assign o_diff_en   = r_diffEn;
  assign o_iter_cnt  = r_iterCnt;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_grover_sequencer.sv
// Scoreboard bench for grover_sequencer: default-latency instance A and a 1/1-latency instance B.
module tb_grover_sequencer;

  typedef struct packed {
    logic       regEn;
    logic [1:0] sel;
    logic       orEn;
    logic       dfEn;
    logic       busy;
    logic       done;
    logic [7:0] cnt;
  } obs_t;

  logic       clk;
  logic       rst_n;
  logic       startA, startB, abortA, abortB;
  logic [7:0] targetA, targetB;
  logic       regEnA, orEnA, dfEnA, busyA, doneA;
  logic       regEnB, orEnB, dfEnB, busyB, doneB;
  logic [1:0] selA, selB;
  logic [7:0] cntA, cntB;
  obs_t       actA, actB;

  obs_t       qA[$];
  obs_t       qB[$];
  logic [7:0] lastA = 8'd0;
  logic [7:0] lastB = 8'd0;
  bit         monHold = 1'b1;
  int         total = 0;
  int         bad = 0;

  grover_sequencer #(.ITER_W(8), .ORACLE_LAT(2), .DIFF_LAT(3)) dutA (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(startA), .i_abort(abortA),
    .i_iter_target(targetA), .o_reg_en(regEnA), .o_sel_src(selA),
    .o_oracle_en(orEnA), .o_diff_en(dfEnA), .o_iter_cnt(cntA),
    .o_busy(busyA), .o_done(doneA)
  );

  grover_sequencer #(.ITER_W(8), .ORACLE_LAT(1), .DIFF_LAT(1)) dutB (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(startB), .i_abort(abortB),
    .i_iter_target(targetB), .o_reg_en(regEnB), .o_sel_src(selB),
    .o_oracle_en(orEnB), .o_diff_en(dfEnB), .o_iter_cnt(cntB),
    .o_busy(busyB), .o_done(doneB)
  );

  assign actA = {regEnA, selA, orEnA, dfEnA, busyA, doneA, cntA};
  assign actB = {regEnB, selB, orEnB, dfEnB, busyB, doneB, cntB};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(input bit r, input logic [1:0] s, input bit o,
                              input bit d, input bit b, input bit dn, input logic [7:0] c);
    obs_t x;
    x = {r, s, o, d, b, dn, c};
    return x;
  endfunction

  function automatic int latOr(input int dut);
    return (dut == 0) ? 2 : 1;
  endfunction

  function automatic int latDf(input int dut);
    return (dut == 0) ? 3 : 1;
  endfunction

  function automatic int runLen(input int dut, input int n);
    return 2 + n * (latOr(dut) + latDf(dut) + 2);
  endfunction

  task automatic checkOutput(input string name, input obs_t act, input obs_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s t=%0t got reg_en=%0b sel=%0d or=%0b df=%0b busy=%0b done=%0b cnt=%0d want reg_en=%0b sel=%0d or=%0b df=%0b busy=%0b done=%0b cnt=%0d",
               name, $time, act.regEn, act.sel, act.orEn, act.dfEn, act.busy, act.done, act.cnt,
               exp.regEn, exp.sel, exp.orEn, exp.dfEn, exp.busy, exp.done, exp.cnt);
    end
  endtask

  // Reference schedule: one cycle per record, INIT, then per iteration the oracle
  // wait/write-back and diffusion wait/write-back, then DONE; abort truncates it.
  task automatic pushRun(input int dut, input int n, input int abortAt);
    obs_t t[$];
    t.push_back(mk(1, 2'd0, 0, 0, 1, 0, 8'd0));
    for (int it = 0; it < n; it++) begin
      for (int k = 0; k < latOr(dut); k++) t.push_back(mk(0, 2'd1, 1, 0, 1, 0, 8'(it)));
      t.push_back(mk(1, 2'd1, 1, 0, 1, 0, 8'(it)));
      for (int k = 0; k < latDf(dut); k++) t.push_back(mk(0, 2'd2, 0, 1, 1, 0, 8'(it)));
      t.push_back(mk(1, 2'd2, 0, 1, 1, 0, 8'(it)));
    end
    t.push_back(mk(0, 2'd0, 0, 0, 1, 1, 8'(n)));
    if (abortAt > 0) begin
      while (t.size() > abortAt) void'(t.pop_back());
    end
    for (int i = 0; i < t.size(); i++) begin
      if (dut == 0) qA.push_back(t[i]);
      else          qB.push_back(t[i]);
    end
  endtask

  // Starts a run of n iterations; optional abort at run cycle abortAt and a
  // stray start (new random target) at run cycle noiseAt. Entered and left at posedge+1.
  task automatic applyStimulus(input int dut, input int n, input int abortAt,
                               input int noiseAt, input bit withAbort);
    int len;
    len = runLen(dut, n);
    if (dut == 0) begin startA = 1'b1; targetA = 8'(n); abortA = withAbort; end
    else          begin startB = 1'b1; targetB = 8'(n); abortB = withAbort; end
    @(posedge clk);
    pushRun(dut, n, abortAt);
    #1;
    startA = 1'b0; startB = 1'b0; abortA = 1'b0; abortB = 1'b0;
    for (int c = 1; c <= len; c++) begin
      if (c == abortAt) begin
        if (dut == 0) abortA = 1'b1; else abortB = 1'b1;
      end
      if (c == noiseAt) begin
        if (dut == 0) begin startA = 1'b1; targetA = 8'($urandom_range(1, 255)); end
        else          begin startB = 1'b1; targetB = 8'($urandom_range(1, 255)); end
      end
      @(posedge clk);
      #1;
      startA = 1'b0; startB = 1'b0; abortA = 1'b0; abortB = 1'b0;
      if (c == abortAt) break;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor for instance A: pops the next expected cycle, or expects idle when empty.
  always @(negedge clk) begin
    obs_t exp;
    if (!monHold) begin
      if (qA.size() > 0) begin
        exp = qA.pop_front();
        lastA = exp.cnt;
      end else begin
        exp = mk(0, 2'd0, 0, 0, 0, 0, lastA);
      end
      checkOutput("dutA_cycle", actA, exp);
    end
  end

  // Monitor for instance B.
  always @(negedge clk) begin
    obs_t exp;
    if (!monHold) begin
      if (qB.size() > 0) begin
        exp = qB.pop_front();
        lastB = exp.cnt;
      end else begin
        exp = mk(0, 2'd0, 0, 0, 0, 0, lastB);
      end
      checkOutput("dutB_cycle", actB, exp);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n, len, ab, nz;
    startA = 1'b0; startB = 1'b0; abortA = 1'b0; abortB = 1'b0;
    targetA = 8'd0; targetB = 8'd0;
    rst_n = 1'b0;
    #3;
    checkOutput("resetA", actA, mk(0, 2'd0, 0, 0, 0, 0, 8'd0));
    checkOutput("resetB", actB, mk(0, 2'd0, 0, 0, 0, 0, 8'd0));
    idleCycles(2);
    rst_n = 1'b1;
    idleCycles(1);
    monHold = 1'b0;
    idleCycles(2);

    $display("[TB] N=2 run with stray start during OR_WAIT, then during DONE");
    applyStimulus(0, 2, 0, 2, 1'b0);
    applyStimulus(0, 2, 0, 16, 1'b0);

    $display("[TB] N=0 run");
    applyStimulus(0, 0, 0, 0, 1'b0);

    $display("[TB] abort in second DF_WAIT, then fresh run");
    applyStimulus(0, 2, 13, 0, 1'b0);
    applyStimulus(0, 1, 0, 0, 1'b0);

    $display("[TB] abort alone in IDLE, then abort with start");
    abortA = 1'b1;
    idleCycles(1);
    abortA = 1'b0;
    idleCycles(1);
    applyStimulus(0, 1, 0, 0, 1'b1);

    $display("[TB] randomized runs");
    for (int r = 0; r < 8; r++) begin
      n   = $urandom_range(0, 4);
      len = runLen(0, n);
      ab  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, len) : 0;
      nz  = $urandom_range(1, len);
      applyStimulus(0, n, ab, nz, 1'b0);
    end

    $display("[TB] asynchronous reset in OR_WB");
    startA = 1'b1; targetA = 8'd2;
    @(posedge clk);
    pushRun(0, 2, 0);
    #1;
    startA = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    monHold = 1'b1;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRstA", actA, mk(0, 2'd0, 0, 0, 0, 0, 8'd0));
    checkOutput("asyncRstB", actB, mk(0, 2'd0, 0, 0, 0, 0, 8'd0));
    qA.delete(); qB.delete();
    lastA = 8'd0; lastB = 8'd0;
    idleCycles(2);
    rst_n = 1'b1;
    idleCycles(2);
    monHold = 1'b0;
    idleCycles(3);

    $display("[TB] 1/1 latency instance, N=255");
    applyStimulus(1, 255, 0, 0, 1'b0);
    idleCycles(3);

    total++;
    if (qA.size() != 0 || qB.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_drain got qA=%0d qB=%0d want 0 0", qA.size(), qB.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/grover_sequencer.md
Name: grover_sequencer

Overview:
- Controller for the state-vector register bank in the Grover search emulator.
- Sequences one initial load, then N Grover iterations. Each iteration is an oracle pass followed by a diffusion pass.
- Drives the register-bank enable and the source-mux select, and gates the oracle and diffusion datapaths.
- Accounts for the fixed pipeline latency of each datapath.
- Start/busy/done handshake toward the top-level emulation controller.

Parameters:
- ITER_W, 8, width of the iteration target and counter.
- ORACLE_LAT, 2, cycles the oracle datapath needs before its output is valid (must be >= 1).
- DIFF_LAT, 3, cycles the diffusion datapath needs before its output is valid (must be >= 1).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to run; sampled only in IDLE.
- abort  input  1  synchronous cancel; honoured in any non-IDLE state.
- iter_target  input  ITER_W  number of Grover iterations; latched on accepted start.
- reg_en  output  1  enable for the state-vector register bank.
- sel_src  output  2  register input mux: 0 = initial superposition, 1 = oracle output, 2 = diffusion output; 3 is unused.
- oracle_en  output  1  oracle datapath active.
- diff_en  output  1  diffusion datapath active.
- iter_cnt  output  ITER_W  completed iterations.
- busy  output  1  high from INIT through DONE inclusive.
- done  output  1  one-cycle pulse on completion.

Behaviour:
- Reset (rst = 0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0: reg_en, sel_src, oracle_en, diff_en, iter_cnt, busy, done.
  - Latched target is 0 and wait counter is 0.
- States: IDLE, INIT, OR_WAIT, OR_WB, DF_WAIT, DF_WB, DONE.
- Outputs are registered (Moore): each reflects the current state.
- IDLE: all enables 0.
  - start = 1 latches iter_target, clears iter_cnt, and moves to INIT.
- INIT, 1 cycle: sel_src = 0, reg_en = 1.
  - If latched target = 0, go to DONE; else go to OR_WAIT.
- OR_WAIT, exactly ORACLE_LAT cycles: oracle_en = 1, sel_src = 1, reg_en = 0.
  - Wait counter loads ORACLE_LAT-1 on entry and counts to 0, then moves to OR_WB.
- OR_WB, 1 cycle: oracle_en = 1, sel_src = 1, reg_en = 1. Then DF_WAIT.
- DF_WAIT, exactly DIFF_LAT cycles: diff_en = 1, sel_src = 2, reg_en = 0. Then DF_WB.
- DF_WB, 1 cycle: diff_en = 1, sel_src = 2, reg_en = 1.
  - iter_cnt increments by 1 on exit.
  - If iter_cnt+1 == target, go to DONE; else go to OR_WAIT.
- DONE, 1 cycle: done = 1, busy = 1, all enables 0. Then IDLE.
- iter_cnt holds its final value in IDLE until the next accepted start.
- Latency:
  - Start accepted at edge t0 means INIT is visible in cycle t0+1.
  - done is visible in cycle t0+2+N*(ORACLE_LAT+DIFF_LAT+2).
  - Example: N=2 with defaults gives done at t0+16.
- Boundary conditions:
  - start while busy: ignored; target is not re-latched.
  - start in the same cycle as done: ignored, because the state is DONE, not IDLE.
  - abort = 1 in any non-IDLE state: next state is IDLE.
    - All enables drop next cycle; no done pulse.
    - iter_cnt keeps the number of completed iterations.
  - abort in IDLE: no effect.
  - abort and start together in IDLE: start wins.
  - Target = 2^ITER_W-1: runs fully with no wrap. The compare is an equality check, so the counter never overflows.
  - Target = 0: INIT write only, then DONE; no oracle_en or diff_en pulse.
  - rst low mid-run: immediate return to IDLE with all outputs 0. The register bank is reset separately.
- sel_src is never 3. reg_en is never high outside INIT, OR_WB and DF_WB.

Decomposition:
- Shared package grover_pkg holds:
  - state enum typedef for the seven states;
  - sel_src encoding constants SRC_INIT = 0, SRC_ORACLE = 1, SRC_DIFF = 2.
- One natural sub-module, grover_wait_counter:
  - loadable down-counter with load value, load, enable and zero flag;
  - instantiated once and shared by OR_WAIT and DF_WAIT.

Test Plan:
- Reset, then start with iter_target=2 and defaults: INIT at t0+1; reg_en high at t0+1, t0+4, t0+8, t0+11, t0+15; done at t0+16; iter_cnt=2.
- iter_target=0: one reg_en with sel_src=0 at t0+1, done at t0+2, oracle_en and diff_en never high.
- start pulsed during OR_WAIT with iter_target changed to 5: ignored; run completes with the original target 2 at t0+16.
- abort during the second iteration's DF_WAIT: IDLE next cycle, no done, iter_cnt=1, all enables 0. A fresh start then runs normally.
- rst driven low mid-OR_WB: all outputs 0 asynchronously, without waiting for a clock edge. After release, the block stays idle until start.
- ORACLE_LAT=1, DIFF_LAT=1, iter_target=255 (ITER_W=8): done at t0+2+255*4 = t0+1022, iter_cnt=255, no counter wrap.
